// File: rtl/fpu_host_if_if.sv
// Host register bus between the CPU side and the FPU host interface block.
//   databus_in  : host write data (host -> block)
//   databus_out : registered host read data (block -> host)
//   addr        : register address
//   cs, rd, wr  : chip select / read / write strobes, active-low
//   end_ack     : host acknowledge of cmd_end, active-high
//   cmd_end     : command finished / irq, active-high
//   busy        : core running
interface fpu_host_if_if;
    logic [7:0] databus_in;
    logic [7:0] databus_out;
    logic [3:0] addr;
    logic       cs;
    logic       rd;
    logic       wr;
    logic       end_ack;
    logic       cmd_end;
    logic       busy;

    modport master (
        output databus_in, addr, cs, rd, wr, end_ack,
        input  databus_out, cmd_end, busy
    );

    modport slave (
        input  databus_in, addr, cs, rd, wr, end_ack,
        output databus_out, cmd_end, busy
    );
endinterface

// File: rtl/fpu_host_if.sv
// Host-side register responder for the FPU. Holds operands, opcode, result
// and status, launches the arithmetic core with a one-cycle start pulse and
// reports completion on cmd_end until the host acknowledges it.
//   clk         : system clock, rising edge
//   arst        : synchronous active-high reset
//   host        : host register bus (slave side)
//   core_a/b    : operand registers
//   core_op     : opcode register
//   core_start  : one-cycle start pulse to the core
//   core_result : core result, valid with core_done
//   core_done   : one-cycle completion pulse from the core
//
// state | meaning
// IDLE  | waiting for a start command, operand writes accepted
// RUN   | core running, watchdog counting
// DONE  | result ready, cmd_end held until end_ack
module fpu_host_if #(
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            arst,
    fpu_host_if_if.slave    host,
    output logic [31:0]     core_a,
    output logic [31:0]     core_b,
    output logic [OP_W-1:0] core_op,
    output logic            core_start,
    input  logic [31:0]     core_result,
    input  logic            core_done
);
    localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic             wr_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      res_q;
    logic [OP_W-1:0]  op_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       dout_q;
    logic             cmd_end_q;
    logic             busy_q;
    logic             start_q;

    logic             wr_commit;
    logic             start_commit;
    logic             reading;
    logic [7:0]       rd_data;

    // One commit per strobe: only the cycle where wr has just fallen.
    assign wr_commit    = !host.cs && !host.wr && wr_q;
    assign start_commit = wr_commit && (host.addr == 4'd9);
    assign reading      = !host.cs && !host.rd;

    always_comb begin
        rd_data = 8'h00;
        case (host.addr)
            4'd0, 4'd1, 4'd2, 4'd3: rd_data = a_q[{host.addr[1:0], 3'b000} +: 8];
            4'd4, 4'd5, 4'd6, 4'd7: rd_data = b_q[{host.addr[1:0], 3'b000} +: 8];
            4'd8:  rd_data = {5'b0, err_q, cmd_end_q, busy_q};
            4'd9:  rd_data = res_q[7:0];
            4'd10: rd_data = res_q[15:8];
            4'd11: rd_data = res_q[23:16];
            4'd12: rd_data = res_q[31:24];
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state     <= IDLE;
            wr_q      <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            dout_q    <= 8'h00;
            cmd_end_q <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            wr_q    <= host.wr;
            dout_q  <= reading ? rd_data : 8'h00;
            start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_commit) begin
                        case (host.addr)
                            4'd0, 4'd1, 4'd2, 4'd3:
                                a_q[{host.addr[1:0], 3'b000} +: 8] <= host.databus_in;
                            4'd4, 4'd5, 4'd6, 4'd7:
                                b_q[{host.addr[1:0], 3'b000} +: 8] <= host.databus_in;
                            4'd8:    op_q <= host.databus_in[OP_W-1:0];
                            default: ;
                        endcase
                    end
                    if (start_commit) begin
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // A completion on the watchdog's last cycle still counts as success.
                    if (core_done) begin
                        res_q     <= core_result;
                        err_q     <= 1'b0;
                        busy_q    <= 1'b0;
                        cmd_end_q <= 1'b1;
                        state     <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        res_q     <= QNAN;
                        err_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        cmd_end_q <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (host.end_ack) begin
                        cmd_end_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign host.databus_out = dout_q;
    assign host.cmd_end     = cmd_end_q;
    assign host.busy        = busy_q;
    assign core_a           = a_q;
    assign core_b           = b_q;
    assign core_op          = op_q;
    assign core_start       = start_q;
endmodule

// File: tb/tb_fpu_host_if.sv
module tb_fpu_host_if;
    localparam int OP_W    = 4;
    localparam int TIMEOUT = 1024;

    logic            clk = 1'b0;
    logic            arst;
    logic [31:0]     core_a;
    logic [31:0]     core_b;
    logic [OP_W-1:0] core_op;
    logic            core_start;
    logic [31:0]     core_result;
    logic            core_done;

    fpu_host_if_if bus ();

    fpu_host_if #(.OP_W(OP_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .arst        (arst),
        .host        (bus),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_op     (core_op),
        .core_start  (core_start),
        .core_result (core_result),
        .core_done   (core_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;

    always @(negedge clk) if (core_start === 1'b1) start_cnt++;

    // Reference model: register contents and command phase (0 idle, 1 done).
    logic [31:0] m_a, m_b, m_res;
    logic [7:0]  m_op;
    logic        m_err;
    int          m_phase;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_err = 0; m_phase = 0;
    endtask

    function automatic logic [7:0] exp_rd(input int a);
        logic [31:0] w;
        w = 0;
        if (a < 4)                 w = m_a >> (8 * a);
        else if (a < 8)            w = m_b >> (8 * (a - 4));
        else if (a == 8)           w = {29'b0, m_err, (m_phase == 1), 1'b0};
        else if (a <= 12)          w = m_res >> (8 * (a - 9));
        return w[7:0];
    endfunction

    task automatic wr_byte(input int a, input logic [7:0] d);
        bus.cs = 0; bus.wr = 0; bus.addr = 4'(a); bus.databus_in = d;
        tick;
        if (m_phase == 0) begin
            if (a < 4)       m_a[8*a +: 8] = d;
            else if (a < 8)  m_b[8*(a-4) +: 8] = d;
            else if (a == 8) m_op = d;
        end
        chk("core_a", core_a, m_a);
        chk("core_b", core_b, m_b);
        chk("core_op", 32'(core_op), 32'(m_op[OP_W-1:0]));
        bus.cs = 1; bus.wr = 1;
        tick;
    endtask

    task automatic rd_byte(input int a);
        bus.cs = 0; bus.rd = 0; bus.addr = 4'(a);
        tick;
        chk($sformatf("rd[%0d]", a), 32'(bus.databus_out), 32'(exp_rd(a)));
        bus.cs = 1; bus.rd = 1;
        tick;
        chk("rd_idle", 32'(bus.databus_out), 0);
    endtask

    task automatic wr_word(input int base, input logic [31:0] w);
        for (int i = 0; i < 4; i++) wr_byte(base + i, w[8*i +: 8]);
    endtask

    // Issue start from IDLE; core_done is sampled at the delay-th edge after
    // the start commit (delay 0 = never).
    task automatic run_cmd(input int delay, input logic [31:0] res);
        int  k, busy_n, st0;
        logic ok;
        st0 = start_cnt;
        bus.cs = 0; bus.wr = 0; bus.addr = 4'd9;
        tick;
        chk("start_now", 32'(core_start), 1);
        chk("busy_rise", 32'(bus.busy), 1);
        bus.cs = 1; bus.wr = 1;
        busy_n = bus.busy ? 1 : 0;
        k = 0;
        while (bus.cmd_end !== 1'b1 && k < TIMEOUT + 20) begin
            k++;
            core_done   = (k == delay);
            core_result = (k == delay) ? res : $urandom;
            tick;
            core_done = 0;
            if (bus.busy) busy_n++;
        end
        ok = (delay >= 1 && delay <= TIMEOUT);
        chk("cmd_end_set", 32'(bus.cmd_end), 1);
        chk("busy_fall", 32'(bus.busy), 0);
        chk("busy_cycles", busy_n, ok ? delay : TIMEOUT);
        chk("start_pulses", start_cnt - st0, 1);
        m_phase = 1;
        m_res   = ok ? res : 32'h7FC0_0000;
        m_err   = !ok;
    endtask

    task automatic ack;
        bus.end_ack = 1;
        tick;
        bus.end_ack = 0;
        chk("cmd_end_clr", 32'(bus.cmd_end), 0);
        m_phase = 0;
    endtask

    task automatic read_status_result;
        for (int a = 8; a <= 12; a++) rd_byte(a);
    endtask

    initial begin
        int st0;
        logic [7:0] hv [4];
        arst = 1; core_done = 0; core_result = 0;
        bus.cs = 1; bus.rd = 1; bus.wr = 1; bus.addr = 0; bus.databus_in = 0; bus.end_ack = 0;
        model_reset();
        tick; tick;
        arst = 0;
        chk("rst_a", core_a, 0);
        chk("rst_b", core_b, 0);
        chk("rst_op", 32'(core_op), 0);
        chk("rst_start", 32'(core_start), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_cmd_end", 32'(bus.cmd_end), 0);
        chk("rst_dout", 32'(bus.databus_out), 0);
        read_status_result();

        // Directed operands and first command
        wr_word(0, 32'h4D96890D);
        wr_word(4, 32'h40000000);
        wr_byte(8, 8'h02);
        for (int a = 0; a < 8; a++) rd_byte(a);
        chk("op_dir", 32'(core_op), 32'h2);
        run_cmd(5, 32'h4E16890D);
        read_status_result();
        chk("res_dir", m_res, 32'h4E16890D);

        // Writes and start are locked out in DONE
        st0 = start_cnt;
        wr_word(0, 32'hFFFFFFFF);
        wr_byte(9, 8'h00);
        chk("a_locked", core_a, 32'h4D96890D);
        chk("no_start_done", start_cnt - st0, 0);
        chk("still_done", 32'(bus.cmd_end), 1);
        ack();

        // Watchdog timeout, then completion on the last watchdog cycle
        run_cmd(0, 32'h0);
        read_status_result();
        ack();
        run_cmd(TIMEOUT, 32'h3F800000);
        read_status_result();

        // Start and end_ack together in DONE: start is dropped
        st0 = start_cnt;
        bus.cs = 0; bus.wr = 0; bus.addr = 4'd9; bus.end_ack = 1;
        tick;
        bus.cs = 1; bus.wr = 1; bus.end_ack = 0;
        m_phase = 0;
        chk("ack_start_cmd_end", 32'(bus.cmd_end), 0);
        tick; tick;
        chk("ack_start_busy", 32'(bus.busy), 0);
        chk("ack_start_nostart", start_cnt - st0, 0);

        // Randomized commands
        for (int it = 0; it < 8; it++) begin
            for (int n = 0; n < 12; n++) begin
                int a;
                a = $urandom_range(0, 14);
                if (a >= 9) a = a + 1;
                wr_byte(a, 8'($urandom));
            end
            for (int n = 0; n < 4; n++) rd_byte($urandom_range(0, 15));
            run_cmd($urandom_range(1, 30), $urandom);
            read_status_result();
            ack();
        end

        // Long write strobe: only the first data byte commits
        for (int i = 0; i < 4; i++) hv[i] = 8'($urandom);
        bus.cs = 0; bus.wr = 0; bus.addr = 4'd0;
        for (int i = 0; i < 4; i++) begin
            bus.databus_in = hv[i];
            tick;
        end
        bus.cs = 1; bus.wr = 1;
        tick;
        m_a[7:0] = hv[0];
        chk("long_wr", core_a, m_a);

        // core_done while IDLE is ignored
        core_done = 1; core_result = $urandom;
        tick;
        core_done = 0;
        tick;
        chk("idle_done_cmd_end", 32'(bus.cmd_end), 0);
        read_status_result();

        // Reset in the middle of a command
        bus.cs = 0; bus.wr = 0; bus.addr = 4'd9;
        tick;
        bus.cs = 1; bus.wr = 1;
        tick; tick;
        st0 = start_cnt;
        arst = 1;
        tick;
        model_reset();
        chk("mid_rst_a", core_a, 0);
        chk("mid_rst_b", core_b, 0);
        chk("mid_rst_op", 32'(core_op), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_cmd_end", 32'(bus.cmd_end), 0);
        chk("mid_rst_start", 32'(core_start), 0);
        chk("mid_rst_dout", 32'(bus.databus_out), 0);
        arst = 0;
        tick;
        core_done = 1; core_result = 32'hDEADBEEF;
        tick;
        core_done = 0;
        tick;
        chk("post_rst_cmd_end", 32'(bus.cmd_end), 0);
        chk("post_rst_nostart", start_cnt - st0, 0);
        read_status_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
